// File: rtl/cpu_sram_arbiter.sv
// cpu_sram_arbiter: merges the instruction-fetch and load/store SRAM-like
// request ports onto one shared SRAM-like bus. One transaction is in flight
// at a time. The data side normally wins. After MAX_DATA_STREAK consecutive
// data grants taken while fetch was waiting, one fetch grant is forced.
module cpu_sram_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    // instruction side
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data side
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // shared bus
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

    state_t      state_q,  state_d;
    logic        owner_q,  owner_d;     // 1'b0 = data side, 1'b1 = inst side
    logic [3:0]  streak_q, streak_d;
    logic        wr_q,     wr_d;
    logic [1:0]  size_q,   size_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;

    logic        grant_data_s;
    logic        grant_inst_s;
    logic        complete_s;

    // Grant decision in IDLE: data wins unless fetch has been starved long enough.
    always_comb begin
        grant_data_s = 1'b0;
        grant_inst_s = 1'b0;
        if (state_q == ST_IDLE) begin
            if (data_req && !(inst_req && (streak_q == MAX_STREAK))) begin
                grant_data_s = 1'b1;
            end else if (inst_req) begin
                grant_inst_s = 1'b1;
            end else begin
                grant_inst_s = 1'b0;
            end
        end else begin
            grant_data_s = 1'b0;
        end
    end

    // State, request buffer and streak register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            streak_q <= 4'd0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next-state logic: latch the winner, then walk through the address and data phases.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        wr_d     = wr_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_data_s) begin
                    owner_d = 1'b0;
                    wr_d    = data_wr;
                    size_d  = data_size;
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                    state_d = ST_ADDR;
                    // Only data grants that skip over a waiting fetch count toward starvation.
                    if (inst_req) begin
                        streak_d = (streak_q >= MAX_STREAK) ? MAX_STREAK : streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                end else if (grant_inst_s) begin
                    owner_d  = 1'b1;
                    wr_d     = inst_wr;
                    size_d   = inst_size;
                    addr_d   = inst_addr;
                    wdata_d  = inst_wdata;
                    streak_d = 4'd0;
                    state_d  = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (bus_addr_ok) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A bus_data_ok only counts while waiting in the data phase.
    assign complete_s = (state_q == ST_DATA) && bus_data_ok;

    // Accept pulses are combinational; reset masks them so nothing is acknowledged while held.
    assign data_addr_ok = grant_data_s && !reset;
    assign inst_addr_ok = grant_inst_s && !reset;

    // Completion and read data route straight through to the owner only.
    assign data_data_ok = complete_s && !owner_q;
    assign inst_data_ok = complete_s &&  owner_q;
    assign data_rdata   = data_data_ok ? bus_rdata : 32'd0;
    assign inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;

    // The bus command is the buffered request; reset clears the buffer.
    assign bus_req   = (state_q == ST_ADDR);
    assign bus_wr    = wr_q;
    assign bus_size  = size_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Bench for cpu_sram_arbiter: expected completions are queued when a grant
// is seen and checked when the matching *_data_ok appears.
module tb_cpu_sram_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    int total;
    int bad;

    typedef struct {
        logic        owner;
        logic [31:0] rdata;
    } sb_t;
    sb_t sb_q[$];

    cpu_sram_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one transaction. Caller has set the request inputs at posedge+1 in IDLE.
    task automatic do_txn(input logic exp_inst, input logic exp_wr, input logic [1:0] exp_size,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata, input int addr_wait, input int data_wait);
        sb_t  e;
        logic [31:0] obs_rd, other_rd;
        @(negedge clk);
        total++;
        if (inst_addr_ok !== exp_inst || data_addr_ok !== !exp_inst) begin
            bad++;
            $display("FAIL grant: inst_addr_ok=%b data_addr_ok=%b, expected inst winner=%b",
                     inst_addr_ok, data_addr_ok, exp_inst);
        end
        sb_q.push_back('{owner: exp_inst, rdata: exp_rdata});
        @(posedge clk); #1;
        for (int i = 0; i <= addr_wait; i++) begin
            bus_addr_ok = (i == addr_wait);
            @(negedge clk);
            total++;
            if ({bus_req, bus_wr, bus_size, bus_addr, bus_wdata} !==
                {1'b1, exp_wr, exp_size, exp_addr, exp_wdata}) begin
                bad++;
                $display("FAIL bus_cmd: req=%b wr=%b size=%0d addr=%h wdata=%h, expected 1 %b %0d %h %h",
                         bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
                         exp_wr, exp_size, exp_addr, exp_wdata);
            end
            total++;
            if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
                bad++;
                $display("FAIL busy_accept: inst_addr_ok=%b data_addr_ok=%b, expected 0 0",
                         inst_addr_ok, data_addr_ok);
            end
            @(posedge clk); #1;
        end
        bus_addr_ok = 1'b0;
        for (int i = 0; i <= data_wait; i++) begin
            bus_data_ok = (i == data_wait);
            bus_rdata   = (i == data_wait) ? exp_rdata : 32'h0F0F_0F0F;
            @(negedge clk);
            total++;
            if (bus_req !== 1'b0) begin
                bad++;
                $display("FAIL bus_req_data_phase: got %b, expected 0", bus_req);
            end
            total++;
            if (i != data_wait) begin
                if ((inst_data_ok | data_data_ok) !== 1'b0) begin
                    bad++;
                    $display("FAIL early_data_ok: inst=%b data=%b, expected 0 0", inst_data_ok, data_data_ok);
                end
            end else if ((inst_data_ok ^ data_data_ok) !== 1'b1) begin
                bad++;
                $display("FAIL data_ok: inst=%b data=%b, expected exactly one", inst_data_ok, data_data_ok);
            end else if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard: completion with size=0, expected an entry");
            end else begin
                e        = sb_q.pop_front();
                obs_rd   = inst_data_ok ? inst_rdata : data_rdata;
                other_rd = inst_data_ok ? data_rdata : inst_rdata;
                if (inst_data_ok !== e.owner || obs_rd !== e.rdata || other_rd !== 32'd0) begin
                    bad++;
                    $display("FAIL completion: owner=%b rdata=%h other_rdata=%h, expected owner=%b rdata=%h other=0",
                             inst_data_ok, obs_rd, other_rd, e.owner, e.rdata);
                end
            end
            @(posedge clk); #1;
        end
        bus_data_ok = 1'b0;
        bus_rdata   = 32'd0;
    endtask

    // Reset holds every output low, even with requests pending.
    task automatic test_reset;
        reset = 1'b1;
        inst_req = 1'b1; data_req = 1'b1;
        inst_wr = 1'b0; data_wr = 1'b0; inst_size = 2'd2; data_size = 2'd2;
        inst_addr = 32'h0000_1000; data_addr = 32'h1000_0000;
        inst_wdata = 32'd0; data_wdata = 32'd0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin
            bad++; $display("FAIL reset_addr_ok: got %b, expected 00", {inst_addr_ok, data_addr_ok});
        end
        total++;
        if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== 66'd0) begin
            bad++; $display("FAIL reset_data: ok=%b%b rdata=%h %h, expected all 0",
                            inst_data_ok, data_data_ok, inst_rdata, data_rdata);
        end
        total++;
        if ({bus_req, bus_wr, bus_size, bus_addr, bus_wdata} !== 68'd0) begin
            bad++; $display("FAIL reset_bus: req=%b addr=%h wdata=%h, expected all 0", bus_req, bus_addr, bus_wdata);
        end
        @(posedge clk); #1;
        inst_req = 1'b0; data_req = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_read;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1000_0004;
        do_txn(1'b0, 1'b0, 2'd2, 32'h1000_0004, 32'd0, 32'hDEAD_BEEF, 0, 0);
        data_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous;
        inst_req = 1'b1; inst_addr = 32'h0000_2000; inst_size = 2'd2;
        data_req = 1'b1; data_addr = 32'h1000_0008; data_size = 2'd2; data_wr = 1'b0;
        do_txn(1'b0, 1'b0, 2'd2, 32'h1000_0008, 32'd0, 32'h1111_2222, 0, 1);
        data_req = 1'b0;
        do_txn(1'b1, 1'b0, 2'd2, 32'h0000_2000, 32'd0, 32'h3333_4444, 1, 0);
        inst_req = 1'b0;
        @(posedge clk); #1;
    endtask

    // Both sides held high: four data grants, one fetch, and the pattern repeats.
    task automatic test_starvation;
        logic [9:0] inst_turn;
        logic       own;
        inst_turn = 10'b10_0001_0000;
        inst_req = 1'b1; inst_addr = 32'h0000_3000; inst_size = 2'd2; inst_wr = 1'b0;
        data_req = 1'b1; data_addr = 32'h1000_0100; data_size = 2'd2; data_wr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            own = inst_turn[i];
            do_txn(own, 1'b0, 2'd2, own ? 32'h0000_3000 : 32'h1000_0100, 32'd0,
                   32'h5000_0000 + 32'(i), 0, 0);
        end
        inst_req = 1'b0; data_req = 1'b0;
        @(posedge clk); #1;
    endtask

    // Address phase stalled for five cycles while the data side keeps requesting.
    task automatic test_bus_stall;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1;
        data_addr = 32'h2000_0002; data_wdata = 32'h1234_5678;
        do_txn(1'b0, 1'b1, 2'd1, 32'h2000_0002, 32'h1234_5678, 32'h0000_0000, 5, 2);
        data_req = 1'b0; data_wr = 1'b0; data_wdata = 32'd0;
        @(posedge clk); #1;
    endtask

    // Handshakes arriving in IDLE must do nothing.
    task automatic test_spurious;
        bus_data_ok = 1'b1; bus_rdata = 32'hAAAA_5555; bus_addr_ok = 1'b1;
        @(negedge clk);
        total++;
        if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== 66'd0) begin
            bad++; $display("FAIL idle_data_ok: ok=%b%b rdata=%h %h, expected all 0",
                            inst_data_ok, data_data_ok, inst_rdata, data_rdata);
        end
        @(posedge clk); #1;
        bus_data_ok = 1'b0; bus_addr_ok = 1'b0; bus_rdata = 32'd0;
        @(negedge clk);
        total++;
        if ({bus_req, inst_data_ok, data_data_ok} !== 3'b000) begin
            bad++; $display("FAIL idle_stray: bus_req=%b data_ok=%b%b, expected 000",
                            bus_req, inst_data_ok, data_data_ok);
        end
        @(posedge clk); #1;
    endtask

    // Reset in the data phase drops the transaction; a late bus_data_ok is ignored.
    task automatic test_reset_mid;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h3000_0000;
        @(negedge clk);
        total++;
        if (data_addr_ok !== 1'b1) begin
            bad++; $display("FAIL mid_accept: data_addr_ok=%b, expected 1", data_addr_ok);
        end
        @(posedge clk); #1;
        data_req = 1'b0; bus_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus_addr_ok = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({bus_req, bus_addr, data_data_ok, inst_data_ok} !== 35'd0) begin
            bad++; $display("FAIL mid_reset: bus_req=%b bus_addr=%h ok=%b%b, expected all 0",
                            bus_req, bus_addr, data_data_ok, inst_data_ok);
        end
        @(posedge clk); #1;
        reset = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        total++;
        if ({data_data_ok, inst_data_ok, data_rdata} !== 34'd0) begin
            bad++; $display("FAIL late_data_ok: ok=%b%b rdata=%h, expected 0", data_data_ok, inst_data_ok, data_rdata);
        end
        @(posedge clk); #1;
        bus_data_ok = 1'b0; bus_rdata = 32'd0;
        data_req = 1'b1; data_addr = 32'h0000_0040;
        do_txn(1'b0, 1'b0, 2'd2, 32'h0000_0040, 32'd0, 32'hCAFE_F00D, 0, 0);
        data_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_starvation();
        test_bus_stall();
        test_spurious();
        test_reset_mid();
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover: size=%0d, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
